// File: rtl/mips_run_pkg.sv
// Shared definitions for the MIPS run controller: state encoding and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_run_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RST_HOLD = 2'd1,
    S_RUN      = 2'd2,
    S_DONE     = 2'd3
  } run_state_t;

  localparam int DEF_RST_HOLD    = 4;
  localparam int DEF_MAX_CYCLES  = 50;
  localparam int DEF_HALT_REPEAT = 3;

  // Core is considered occupied while it is held in reset or running.
  function automatic logic state_is_busy(input run_state_t s);
    return (s == S_RST_HOLD) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
// Latency: 1 cycle from clr/inc to q.
// Backpressure: none; clr takes priority over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, hold at all-ones, clear on request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Sequences core reset, counts RUN cycles/retired instructions, stops on halt, budget or abort.
// Latency: flags/counters for a cycle appear with the state change on the next clk edge.
// Backpressure: none; start is ignored while busy, abort wins over start outside IDLE.
module run_controller
  import mips_run_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32,
  parameter int RST_HOLD    = DEF_RST_HOLD,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  input  logic             retire,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam logic [7:0] HOLD_LOAD = 8'(RST_HOLD - 1);
  // Count value seen in the last RUN cycle of a full budget; unused when MAX_CYCLES is 0.
  localparam logic [CNT_W-1:0] LAST_CYC = (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

  run_state_t      state, state_nxt;
  logic [7:0]      hold_q, hold_nxt;
  logic [PC_W-1:0] last_pc;
  logic            pc_seen;
  logic [RW-1:0]   rep_q, rep_nxt;
  logic            in_run, start_ok, halt_hit, tmo_hit;

  assign in_run = (state == S_RUN);
  // In IDLE abort is meaningless, so start proceeds; in DONE abort keeps us parked.
  assign start_ok = start && ((state == S_IDLE) || ((state == S_DONE) && !abort));

  // Repeat tracking: a valid matching pc extends the run, any other valid pc restarts it.
  always_comb begin
    rep_nxt = rep_q;
    if (pc_valid) begin
      if (pc_seen && (pc == last_pc)) rep_nxt = rep_q + 1'b1;
      else                            rep_nxt = RW'(1);
    end
  end

  assign halt_hit = in_run && pc_valid && (rep_nxt == RW'(HALT_REPEAT));
  assign tmo_hit  = in_run && (MAX_CYCLES != 0) && (cycle_count == LAST_CYC);

  // Next-state and hold-counter decode.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RST_HOLD;
          hold_nxt  = HOLD_LOAD;
        end
      end
      S_RST_HOLD: begin
        if (abort)              state_nxt = S_DONE;
        else if (hold_q == '0)  state_nxt = S_RUN;
        else                    hold_nxt  = hold_q - 1'b1;
      end
      S_RUN: begin
        if (abort || halt_hit || tmo_hit) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start && !abort) begin
          state_nxt = S_RST_HOLD;
          hold_nxt  = HOLD_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and hold-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      hold_q <= '0;
    end else begin
      state  <= state_nxt;
      hold_q <= hold_nxt;
    end
  end

  // Sticky end-of-run flags; an abort in the same cycle suppresses both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted  <= 1'b0;
      timeout <= 1'b0;
    end else if (start_ok) begin
      halted  <= 1'b0;
      timeout <= 1'b0;
    end else if (in_run && !abort) begin
      if (halt_hit) halted  <= 1'b1;
      if (tmo_hit)  timeout <= 1'b1;
    end
  end

  // PC history is only tracked while the core runs, and forgotten at each new run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc <= '0;
      pc_seen <= 1'b0;
      rep_q   <= '0;
    end else if (start_ok) begin
      last_pc <= '0;
      pc_seen <= 1'b0;
      rep_q   <= '0;
    end else if (in_run && pc_valid) begin
      last_pc <= pc;
      pc_seen <= 1'b1;
      rep_q   <= rep_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .inc   (in_run),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .inc   (in_run && retire),
    .q     (retired_count)
  );

  // Decoded straight from the state register so async reset reaches the core at once.
  assign core_reset = (state != S_RUN);
  assign busy       = state_is_busy(state);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] pc;
  logic        pc_valid;
  logic        retire;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        halted;
  logic        timeout;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic halted;
    logic timeout;
    int   cyc;
    int   ret;
  } exp_t;

  exp_t sb[$];

  logic [31:0] t_pc[6];
  logic        t_v[6];

  run_controller #(
    .CNT_W(32), .PC_W(32), .RST_HOLD(4), .MAX_CYCLES(50), .HALT_REPEAT(3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .retire        (retire),
    .core_reset    (core_reset),
    .busy          (busy),
    .done          (done),
    .halted        (halted),
    .timeout       (timeout),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then walk through the reset hold into the first RUN cycle.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_busy_0", busy, 1);
    chk("hold_core_reset_0", core_reset, 1);
    chk("hold_done_clr", done, 0);
    chk("hold_cycle_clr", cycle_count, 0);
    chk("hold_retired_clr", retired_count, 0);
    chk("hold_halted_clr", halted, 0);
    chk("hold_timeout_clr", timeout, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("hold_core_reset", core_reset, 1);
      chk("hold_busy", busy, 1);
    end
    tick();
    chk("run_first_core_reset", core_reset, 0);
    chk("run_first_busy", busy, 1);
  endtask

  // Drive one of the stimulus patterns until DONE (bounded).
  task automatic run_until_done(input int mode, input int abort_at, input bit start_too,
                                output int ncyc);
    int k = 0;
    while (done !== 1'b1 && k < 200) begin
      case (mode)
        0: begin pc = k * 4; pc_valid = 1'b1; retire = (k % 2 == 0); end
        1: begin pc = (k < 2) ? k * 4 : 8; pc_valid = 1'b1; retire = 1'b1; end
        2: begin
          if (k < 6) begin pc = t_pc[k]; pc_valid = t_v[k]; end
          else begin pc = k * 4 + 32'h200; pc_valid = 1'b1; end
          retire = 1'b0;
        end
        default: begin pc = k * 4 + 32'h40; pc_valid = 1'b1; retire = 1'b1; end
      endcase
      abort = (k == abort_at);
      start = start_too && (k == abort_at);
      tick();
      k++;
    end
    pc_valid = 1'b0;
    retire   = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
    ncyc     = k;
    chk("run_reached_done", done, 1);
  endtask

  // Pop the outcome recorded when the run was launched and compare.
  task automatic check_result(input int ncyc);
    exp_t e;
    chk("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_halted", halted, e.halted);
      chk("res_timeout", timeout, e.timeout);
      chk("res_cycle_count", cycle_count, e.cyc);
      chk("res_retired_count", retired_count, e.ret);
      chk("res_run_length", ncyc, e.cyc);
      chk("res_busy", busy, 0);
      chk("res_core_reset", core_reset, 1);
    end
  endtask

  initial begin
    int n;
    t_pc = '{32'd0, 32'd8, 32'h100, 32'd8, 32'h104, 32'd8};
    t_v  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pc = '0; pc_valid = 1'b0; retire = 1'b0;
    #23;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_halted", halted, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_retired_count", retired_count, 0);
    reset = 1'b1;
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    chk("idle_abort_ignored", {busy, done}, 2'b00);

    // Budget run: pc always changing, retire every other cycle.
    sb.push_back('{1'b0, 1'b1, 50, 25});
    do_start();
    run_until_done(0, -1, 1'b0, n);
    check_result(n);
    for (int i = 0; i < 3; i++) begin
      pc = 32'h300 + i; pc_valid = 1'b1; retire = 1'b1;
      tick();
    end
    pc_valid = 1'b0; retire = 1'b0;
    chk("frozen_cycle_count", cycle_count, 50);
    chk("frozen_retired_count", retired_count, 25);
    chk("frozen_done", done, 1);
    chk("frozen_timeout", timeout, 1);

    // Halt on 0,4,8,8,8.
    sb.push_back('{1'b1, 1'b0, 5, 5});
    do_start();
    run_until_done(1, -1, 1'b0, n);
    check_result(n);

    // Halt with invalid cycles interleaved in the repeat.
    sb.push_back('{1'b1, 1'b0, 6, 0});
    do_start();
    run_until_done(2, -1, 1'b0, n);
    check_result(n);

    // Abort in the 10th RUN cycle.
    sb.push_back('{1'b0, 1'b0, 10, 10});
    do_start();
    run_until_done(3, 9, 1'b0, n);
    check_result(n);

    // Restart from DONE, then async reset in the middle of RUN.
    do_start();
    for (int i = 0; i < 5; i++) begin
      pc = i * 4; pc_valid = 1'b1;
      tick();
    end
    pc_valid = 1'b0;
    chk("mid_run_core_reset", core_reset, 0);
    chk("mid_run_cycle_count", cycle_count, 5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_core_reset", core_reset, 1);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_cycle_count", cycle_count, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
    chk("post_rst_idle", {busy, done, core_reset}, 3'b001);

    // start together with abort while running: DONE, no restart.
    sb.push_back('{1'b0, 1'b0, 3, 3});
    do_start();
    run_until_done(3, 2, 1'b1, n);
    check_result(n);
    tick();
    tick();
    chk("no_restart_done", done, 1);
    chk("no_restart_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
